// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receive path.
// Frame = start, DATA_W data bits LSB-first, optional parity slot, stop.
module uart_receiver #(
    parameter int DATA_W      = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_EVEN = 1,
    parameter int OSR         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              oversample_tick,
    input  logic              RsRx,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    localparam int TICK_W = $clog2(OSR);
    localparam int BIT_W  = $clog2(DATA_W + 1);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OSR / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OSR - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    // The parity sense only has to be legal; the bit itself is never checked.
    localparam bit PAR_SLOT =
        (PARITY_EN != 0) && ((PARITY_EVEN == 0) || (PARITY_EVEN == 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                rx_meta_q;
    logic                rx_sync_q;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = 1'b0;

        if (oversample_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_sync_q) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end

                S_START: begin
                    if (tick_q == HALF_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        // New bit enters at the MSB; the first bit ends at bit 0.
                        shift_d = DATA_W'({rx_sync_q, shift_q} >> 1);
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = PAR_SLOT ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        state_d = S_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                S_STOP: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d = '0;
                        if (rx_sync_q) begin
                            dout_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                S_BREAK: begin
                    if (rx_sync_q) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            rx_meta_q <= RsRx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: random and directed frames on six receiver configurations,
// checked against a per-line expected-word list.
module tb_uart_receiver;

    localparam int OSR      = 16;
    localparam int TICK_DIV = 20;
    localparam int N        = 6;

    int wid [N] = '{8, 1, 16, 32, 8, 8};
    int par [N] = '{0, 0, 0, 0, 1, 1};
    int pev [N] = '{1, 1, 1, 1, 1, 0};

    logic         clk = 1'b0;
    logic         reset;
    logic         tick;
    logic [N-1:0] rx_line;
    logic [N-1:0] dv;
    logic [N-1:0] dv_prev;
    logic [7:0]   d0, d4, d5;
    logic [0:0]   d1;
    logic [15:0]  d2;
    logic [31:0]  d3;
    logic [31:0]  dout [N];

    logic [31:0] exp_val [N][64];
    int          exp_cnt [N];
    int          got_cnt [N];
    logic [31:0] model_out [N];

    int errors = 0;
    int checks = 0;
    int div_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div_cnt <= (div_cnt == TICK_DIV - 1) ? 0 : div_cnt + 1;
    end
    assign tick = (div_cnt == TICK_DIV - 1);

    assign dout[0] = {24'd0, d0};
    assign dout[1] = {31'd0, d1};
    assign dout[2] = {16'd0, d2};
    assign dout[3] = d3;
    assign dout[4] = {24'd0, d4};
    assign dout[5] = {24'd0, d5};

    uart_receiver #(.DATA_W(8), .PARITY_EN(0), .PARITY_EVEN(1), .OSR(OSR)) u_w8 (
        .clk(clk), .reset(reset), .oversample_tick(tick),
        .RsRx(rx_line[0]), .data_out(d0), .data_valid(dv[0]));
    uart_receiver #(.DATA_W(1), .PARITY_EN(0), .PARITY_EVEN(1), .OSR(OSR)) u_w1 (
        .clk(clk), .reset(reset), .oversample_tick(tick),
        .RsRx(rx_line[1]), .data_out(d1), .data_valid(dv[1]));
    uart_receiver #(.DATA_W(16), .PARITY_EN(0), .PARITY_EVEN(1), .OSR(OSR)) u_w16 (
        .clk(clk), .reset(reset), .oversample_tick(tick),
        .RsRx(rx_line[2]), .data_out(d2), .data_valid(dv[2]));
    uart_receiver #(.DATA_W(32), .PARITY_EN(0), .PARITY_EVEN(1), .OSR(OSR)) u_w32 (
        .clk(clk), .reset(reset), .oversample_tick(tick),
        .RsRx(rx_line[3]), .data_out(d3), .data_valid(dv[3]));
    uart_receiver #(.DATA_W(8), .PARITY_EN(1), .PARITY_EVEN(1), .OSR(OSR)) u_pe (
        .clk(clk), .reset(reset), .oversample_tick(tick),
        .RsRx(rx_line[4]), .data_out(d4), .data_valid(dv[4]));
    uart_receiver #(.DATA_W(8), .PARITY_EN(1), .PARITY_EVEN(0), .OSR(OSR)) u_po (
        .clk(clk), .reset(reset), .oversample_tick(tick),
        .RsRx(rx_line[5]), .data_out(d5), .data_valid(dv[5]));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!tick);
        end
        #1;
    endtask

    task automatic send_bit(input int i, input logic b);
        rx_line[i] = b;
        wait_ticks(OSR);
    endtask

    task automatic send_frame(input int i, input logic [31:0] data,
                              input logic stop);
        logic [31:0] m;
        logic [31:0] d;
        m = (wid[i] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << wid[i]) - 32'd1);
        d = data & m;
        if (stop) begin
            exp_val[i][exp_cnt[i]] = d;
            exp_cnt[i]++;
            model_out[i] = d;
        end
        send_bit(i, 1'b0);
        for (int k = 0; k < wid[i]; k++) send_bit(i, d[k]);
        if (par[i] != 0) send_bit(i, (pev[i] != 0) ? ^d : ~^d);
        send_bit(i, stop);
    endtask

    task automatic gap(input int i);
        rx_line[i] = 1'b1;
        wait_ticks($urandom_range(0, 20));
    endtask

    task automatic settle(input int i);
        wait_ticks(4);
        check($sformatf("pulses[%0d]", i), got_cnt[i], exp_cnt[i]);
        check($sformatf("data_out[%0d]", i), dout[i], model_out[i]);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (dv[i]) begin
                    check($sformatf("dv_one_cycle[%0d]", i),
                          {31'd0, dv_prev[i]}, 32'd0);
                    if (got_cnt[i] < exp_cnt[i])
                        check($sformatf("pulse_word[%0d]", i),
                              dout[i], exp_val[i][got_cnt[i]]);
                    else
                        check($sformatf("unexpected_pulse[%0d]", i),
                              got_cnt[i] + 1, exp_cnt[i]);
                    got_cnt[i]++;
                end
            end
            dv_prev = dv;
        end
    endtask

    initial begin
        reset   = 1'b1;
        rx_line = '1;
        dv_prev = '0;
        for (int i = 0; i < N; i++) begin
            exp_cnt[i]   = 0;
            got_cnt[i]   = 0;
            model_out[i] = '0;
        end
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_valid[%0d]", i), {31'd0, dv[i]}, 32'd0);
            check($sformatf("rst_data[%0d]", i), dout[i], 32'd0);
        end
        fork
            monitor();
        join_none

        // Idle line for 20 bit times.
        wait_ticks(20 * OSR);
        for (int i = 0; i < N; i++)
            check($sformatf("idle_pulses[%0d]", i), got_cnt[i], 0);

        fork
            begin
                send_frame(3, 32'h0000_00A5, 1'b1);
                settle(3);
            end
            begin
                send_frame(2, 32'h0000_00A5, 1'b1);
                settle(2);
                gap(2);
                send_frame(2, $urandom, 1'b1);
                settle(2);
            end
            begin
                send_frame(1, 32'd1, 1'b1);
                settle(1);
                for (int k = 0; k < 6; k++) begin
                    gap(1);
                    send_frame(1, $urandom, 1'b1);
                    settle(1);
                end
            end
            begin
                send_frame(4, 32'hA5, 1'b1);
                settle(4);
                gap(4);
                send_frame(4, $urandom, 1'b1);
                settle(4);
            end
            begin
                send_frame(5, 32'hA5, 1'b1);
                settle(5);
                gap(5);
                send_frame(5, $urandom, 1'b1);
                settle(5);
            end
            begin
                send_frame(0, 32'hA5, 1'b1);
                settle(0);
                for (int k = 0; k < 2; k++) begin
                    gap(0);
                    send_frame(0, $urandom, 1'b1);
                    settle(0);
                end
            end
        join

        // Start glitch shorter than half a bit, then a frame of zero.
        rx_line[0] = 1'b0;
        wait_ticks(OSR / 4);
        send_bit(0, 1'b1);
        send_frame(0, 32'h00, 1'b1);
        settle(0);

        // Framing error: stop held low, line stays low, then recovers.
        gap(0);
        send_frame(0, 32'hA5, 1'b0);
        wait_ticks(2 * OSR);
        rx_line[0] = 1'b1;
        wait_ticks(2 * OSR);
        settle(0);
        send_frame(0, $urandom, 1'b1);
        settle(0);

        // Back-to-back frames with no idle gap.
        gap(0);
        send_frame(0, 32'hA5, 1'b1);
        send_frame(0, 32'h3C, 1'b1);
        settle(0);

        // Reset in the middle of the data bits.
        gap(0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        wait_ticks(OSR / 2);
        rx_line[0] = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_valid", {31'd0, dv[0]}, 32'd0);
        check("mid_rst_data", dout[0], 32'd0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) model_out[i] = '0;
        wait_ticks(2 * OSR);
        send_frame(0, 32'h3C, 1'b1);
        settle(0);

        for (int i = 0; i < N; i++) begin
            check($sformatf("final_pulses[%0d]", i), got_cnt[i], exp_cnt[i]);
            check($sformatf("final_data[%0d]", i), dout[i], model_out[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
